sistema_memoria: RTL and testbench
==================================

SISTEMA_MEMORIA -- requirements
Module: sistema_memoria

Interface
REQ-001 Parameter ADDR_W, default 16: byte-address width of the instruction and data ports.
REQ-002 Parameter DEPTH_WORDS, default 1024: number of 32-bit words in the unified memory array.
REQ-003 Parameter WAIT, default 1, range 0..15: extra wait cycles added to every data access.
REQ-004 Parameter IO_BASE, default 16'hFF00: byte address of the input register; IO_BASE+4 is the output register.
REQ-005 clk  in  1: single clock; all state updates on its rising edge.
REQ-006 rst  in  1: asynchronous, active-high reset.
REQ-007 pc_s  in  ADDR_W: instruction byte address.
REQ-008 instruccion_s  out  32: instruction word at pc_s.
REQ-009 addrData_s  in  ADDR_W: data byte address.
REQ-010 dataWrite_s  in  32: store data, right-aligned.
REQ-011 we_s  in  1: store request.
REQ-012 re_s  in  1: load request.
REQ-013 funct3_s  in  3: access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-014 dataRead_s  out  32: load result, registered.
REQ-015 ready_s  out  1: one-cycle completion pulse.
REQ-016 err_s  out  1: sticky error flag, set on a faulting access.
REQ-017 ent  in  32: external input word.
REQ-018 sal  out  32: external output register.

Function
REQ-019 instruccion_s shall be a combinational read of word pc_s[ADDR_W-1:2]; pc_s[1:0] is ignored; an out-of-range word reads 32'h00000013 (NOP).
REQ-020 Data FSM states: IDLE, BUSY, DONE.
REQ-021 In IDLE, a request (we_s or re_s) at a rising edge shall latch address, data, funct3 and direction; the FSM goes to BUSY with the counter at WAIT, or directly to DONE when WAIT=0.
REQ-022 In BUSY, the counter shall decrement each cycle; when it reaches 0 the FSM goes to DONE.
REQ-023 DONE lasts exactly one cycle with ready_s=1, then the FSM returns to IDLE; requests are sampled only in IDLE.
REQ-024 Latency: ready_s shall be high in the cycle WAIT+1 edges after the sampling edge.
REQ-025 The requester holds the request until ready_s and deasserts it, or changes it, in the following cycle.
REQ-026 we_s and re_s both high: treat as a store and set err_s.
REQ-027 Store byte lanes: SB writes lane addr[1:0]; SH writes the lanes selected by addr[1]; SW writes all four lanes; other lanes are unchanged; the write commits at the edge entering DONE.
REQ-028 Load: dataRead_s is updated at the edge entering DONE; LB/LH sign-extend, LBU/LHU zero-extend; dataRead_s holds its value until the next load completes.
REQ-029 Misaligned access: LH/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, shall still complete with ready_s, suppress the write, leave dataRead_s unchanged and set err_s.
REQ-030 Addresses at or above 4*DEPTH_WORDS that are not I/O: loads return 0; stores are dropped; err_s is set.
REQ-031 A word load at IO_BASE shall return ent as sampled at the edge entering DONE.
REQ-032 A word store at IO_BASE+4 shall update sal at the edge entering DONE; sub-word I/O accesses shall set err_s.
REQ-033 Undefined funct3 values: treated as misaligned (REQ-029 behaviour).
REQ-034 err_s is cleared only by reset.

Reset
REQ-035 On rst=1 the block shall immediately enter IDLE with counter=0, ready_s=0, err_s=0, dataRead_s=0 and sal=0; memory contents are not reset.
REQ-036 Reset asserted while in BUSY shall drop the pending access; no write occurs and no ready_s is produced.

Verification
REQ-037 WAIT=1: SW 0xDEADBEEF at 0x0010, then LW 0x0010 -> each ready_s two cycles after sampling; dataRead_s=0xDEADBEEF.
REQ-038 SB 0x80 at 0x0013, then LB and LBU at 0x0013 -> 0xFFFFFF80 and 0x00000080; word at 0x0010 = 0x80ADBEEF.
REQ-039 LW at 0x0012 -> ready_s pulses, dataRead_s unchanged, err_s=1 and stays 1 until rst.
REQ-040 ent=0x12345678, LW at IO_BASE -> 0x12345678; SW 0xA5 at IO_BASE+4 -> sal=0x000000A5.
REQ-041 rst pulsed mid-BUSY during SW 0x1 at 0x0020 -> no ready_s; a later LW at 0x0020 returns the prior contents; all outputs are at reset values during rst.
REQ-042 WAIT=0, back-to-back requests -> ready_s every second cycle; instruccion_s tracks pc_s combinationally throughout.

Source files
------------

// File: rtl/sistema_memoria.sv
// Unified instruction/data memory with a wait-stated data port and two memory-mapped I/O words.
// Instruction reads are combinational; data accesses run through an IDLE/BUSY/DONE handshake.
module sistema_memoria #(
    parameter int                ADDR_W      = 16,
    parameter int                DEPTH_WORDS = 1024,
    parameter int                WAIT        = 1,
    parameter logic [ADDR_W-1:0] IO_BASE     = 16'hFF00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_s,
    output logic [31:0]       instruccion_s,
    input  logic [ADDR_W-1:0] addrData_s,
    input  logic [31:0]       dataWrite_s,
    input  logic              we_s,
    input  logic              re_s,
    input  logic [2:0]        funct3_s,
    output logic [31:0]       dataRead_s,
    output logic              ready_s,
    output logic              err_s,
    input  logic [31:0]       ent,
    output logic [31:0]       sal
);
    localparam int                IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W-1:0] IO_OUT = IO_BASE + ADDR_W'(4);
    localparam logic [31:0]       NOP    = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    logic [31:0] mem [DEPTH_WORDS];

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q, rdata_q, sal_q;
    logic [2:0]        f3_q;
    logic              st_q, both_q, err_q;

    logic [ADDR_W-3:0] pidx, eidx;
    assign pidx = pc_s[ADDR_W-1:2];
    always_comb instruccion_s = (32'(pidx) < DEPTH_WORDS) ? mem[pidx[IDX_W-1:0]] : NOP;

    // Effective request: live inputs when the access commits on its sampling edge (WAIT=0)
    logic              idle, req, est, eboth;
    logic [ADDR_W-1:0] ea;
    logic [31:0]       ed;
    logic [2:0]        ef;
    assign idle  = (state_q == IDLE);
    assign req   = we_s | re_s;
    assign ea    = idle ? addrData_s : addr_q;
    assign ed    = idle ? dataWrite_s : wdata_q;
    assign ef    = idle ? funct3_s : f3_q;
    assign est   = idle ? we_s : st_q;
    assign eboth = idle ? (we_s & re_s) : both_q;
    assign eidx  = ea[ADDR_W-1:2];

    logic is_byte, is_half, is_word, valid, misal, io_in, io_out, is_io, io_bad, oor, blk;
    always_comb begin
        is_byte = (ef[1:0] == 2'b00);
        is_half = (ef[1:0] == 2'b01);
        is_word = (ef == 3'b010);
        valid   = (ef == 3'b000) || (ef == 3'b001) || (ef == 3'b010) ||
                  (!est && ((ef == 3'b100) || (ef == 3'b101)));
        misal   = !valid || (is_half && ea[0]) || (is_word && (ea[1:0] != 2'b00));
        io_in   = (ea == IO_BASE);
        io_out  = (ea == IO_OUT);
        is_io   = io_in | io_out;
        // Input register is read-only; the output register may be read back
        io_bad  = is_io && (!is_word || (est && io_in));
        oor     = !is_io && !(32'(eidx) < DEPTH_WORDS);
        blk     = misal | io_bad | oor;
    end

    logic [3:0]  be;
    logic [31:0] wsh, sh, lext, lval;
    always_comb begin
        wsh = ed << {ea[1:0], 3'b000};
        if (is_word)      be = 4'b1111;
        else if (is_half) be = ea[1] ? 4'b1100 : 4'b0011;
        else              be = 4'b0001 << ea[1:0];
        sh = mem[eidx[IDX_W-1:0]] >> {ea[1:0], 3'b000};
        if (is_byte)      lext = {{24{~ef[2] & sh[7]}}, sh[7:0]};
        else if (is_half) lext = {{16{~ef[2] & sh[15]}}, sh[15:0]};
        else              lext = sh;
        if (oor)          lval = 32'h0;
        else if (io_in)   lval = ent;
        else if (io_out)  lval = sal_q;
        else              lval = lext;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (req) begin
                cnt_d   = 4'(WAIT);
                state_d = (WAIT == 0) ? DONE : BUSY;
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    logic commit;
    assign commit = !rst && (state_q != DONE) && (state_d == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            f3_q    <= 3'b000;
            st_q    <= 1'b0;
            both_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
            sal_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (idle && req) begin
                addr_q  <= addrData_s;
                wdata_q <= dataWrite_s;
                f3_q    <= funct3_s;
                st_q    <= we_s;
                both_q  <= we_s & re_s;
            end
            if (commit) begin
                if (eboth || blk)                   err_q   <= 1'b1;
                if (!est && !misal && !io_bad)      rdata_q <= lval;
                if (est && io_out && !blk)          sal_q   <= ed;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit && est && !blk && !is_io)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[eidx[IDX_W-1:0]][8*i +: 8] <= wsh[8*i +: 8];
    end

    always_comb begin
        ready_s    = (state_q == DONE);
        err_s      = err_q;
        dataRead_s = rdata_q;
        sal        = sal_q;
    end
endmodule

// File: tb/tb_sistema_memoria.sv
// Scoreboard bench for sistema_memoria: instance 0 uses WAIT=1, instance 1 uses WAIT=0.
module tb_sistema_memoria;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] ent;
    logic [15:0] pc [2], addr [2];
    logic [31:0] wd [2], rd [2], instr [2], sal [2];
    logic [2:0]  f3 [2];
    logic        we [2], re [2], ready [2], err [2];
    int          checks = 0, errors = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    sistema_memoria #(.WAIT(1)) dut (
        .clk(clk), .rst(rst), .pc_s(pc[0]), .instruccion_s(instr[0]),
        .addrData_s(addr[0]), .dataWrite_s(wd[0]), .we_s(we[0]), .re_s(re[0]),
        .funct3_s(f3[0]), .dataRead_s(rd[0]), .ready_s(ready[0]), .err_s(err[0]),
        .ent(ent), .sal(sal[0])
    );

    sistema_memoria #(.WAIT(0)) dut0 (
        .clk(clk), .rst(rst), .pc_s(pc[1]), .instruccion_s(instr[1]),
        .addrData_s(addr[1]), .dataWrite_s(wd[1]), .we_s(we[1]), .re_s(re[1]),
        .funct3_s(f3[1]), .dataRead_s(rd[1]), .ready_s(ready[1]), .err_s(err[1]),
        .ent(ent), .sal(sal[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input int u);
        check($sformatf("rst ready%0d", u), {31'b0, ready[u]}, 32'h0);
        check($sformatf("rst err%0d", u), {31'b0, err[u]}, 32'h0);
        check($sformatf("rst rd%0d", u), rd[u], 32'h0);
        check($sformatf("rst sal%0d", u), sal[u], 32'h0);
    endtask

    task automatic pulse_reset();
        @(negedge clk) rst = 1'b1;
        #1 chk_reset(0);
        chk_reset(1);
        @(negedge clk) rst = 1'b0;
    endtask

    // Called at a negedge with the unit idle; returns at a negedge with the unit idle again
    task automatic access(input string tag, input int u, input bit w, input bit r,
                          input logic [15:0] a, input logic [2:0] f, input logic [31:0] d,
                          input logic [31:0] exp_rd, input bit exp_err);
        int cyc;
        logic [31:0] e;
        exp_q.push_back(exp_rd);
        we[u] = w; re[u] = r; addr[u] = a; f3[u] = f; wd[u] = d;
        cyc = 0;
        do begin
            @(posedge clk); cyc++;
            @(negedge clk);
        end while (!ready[u] && cyc < 40);
        check({tag, " latency"}, cyc, (u == 0) ? 32'd2 : 32'd1);
        e = exp_q.pop_front();
        check({tag, " dataRead"}, rd[u], e);
        check({tag, " err"}, {31'b0, err[u]}, {31'b0, exp_err});
        we[u] = 1'b0; re[u] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            we[u] = 0; re[u] = 0; addr[u] = '0; f3[u] = '0; wd[u] = '0; pc[u] = '0;
        end
        ent = 32'h0;
        #1 rst = 1'b1;
        #3 chk_reset(0);
        chk_reset(1);
        @(negedge clk) rst = 1'b0;

        // Word, byte and half accesses, WAIT=1
        access("SW 10", 0, 1, 0, 16'h0010, 3'b010, 32'hDEADBEEF, 32'h0, 0);
        access("LW 10", 0, 0, 1, 16'h0010, 3'b010, 32'h0, 32'hDEADBEEF, 0);
        access("SB 13", 0, 1, 0, 16'h0013, 3'b000, 32'h00000080, 32'hDEADBEEF, 0);
        access("LB 13", 0, 0, 1, 16'h0013, 3'b000, 32'h0, 32'hFFFFFF80, 0);
        access("LBU 13", 0, 0, 1, 16'h0013, 3'b100, 32'h0, 32'h00000080, 0);
        access("LW 10b", 0, 0, 1, 16'h0010, 3'b010, 32'h0, 32'h80ADBEEF, 0);
        access("LH 12", 0, 0, 1, 16'h0012, 3'b001, 32'h0, 32'hFFFF80AD, 0);
        access("LHU 12", 0, 0, 1, 16'h0012, 3'b101, 32'h0, 32'h000080AD, 0);

        pc[0] = 16'h0010; #1 check("instr 10", instr[0], 32'h80ADBEEF);
        pc[0] = 16'h0013; #1 check("instr 13", instr[0], 32'h80ADBEEF);
        pc[0] = 16'h1000; #1 check("instr oor", instr[0], 32'h00000013);
        @(negedge clk);

        // Memory-mapped I/O
        ent = 32'h12345678;
        access("LW io", 0, 0, 1, 16'hFF00, 3'b010, 32'h0, 32'h12345678, 0);
        access("SW io", 0, 1, 0, 16'hFF04, 3'b010, 32'h000000A5, 32'h12345678, 0);
        check("sal", sal[0], 32'h000000A5);

        // Misalignment: completes, dataRead unchanged, write suppressed, err sticky
        access("LW 12 mis", 0, 0, 1, 16'h0012, 3'b010, 32'h0, 32'h12345678, 1);
        access("SW 11 mis", 0, 1, 0, 16'h0011, 3'b010, 32'hFFFFFFFF, 32'h12345678, 1);
        access("LW 10c", 0, 0, 1, 16'h0010, 3'b010, 32'h0, 32'h80ADBEEF, 1);

        pulse_reset();
        access("SW 20", 0, 1, 0, 16'h0020, 3'b010, 32'hCAFE0000, 32'h0, 0);

        // Reset while BUSY drops the store
        we[0] = 1'b1; addr[0] = 16'h0020; f3[0] = 3'b010; wd[0] = 32'h1;
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk_reset(0);
        we[0] = 1'b0;
        @(posedge clk);
        #1 check("rst hold ready", {31'b0, ready[0]}, 32'h0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk) check("no ready after rst", {31'b0, ready[0]}, 32'h0);
        access("LW 20", 0, 0, 1, 16'h0020, 3'b010, 32'h0, 32'hCAFE0000, 0);

        access("LW oor", 0, 0, 1, 16'h1000, 3'b010, 32'h0, 32'h0, 1);
        pulse_reset();
        access("WE+RE 24", 0, 1, 1, 16'h0024, 3'b010, 32'h00000077, 32'h0, 1);
        access("LW 24", 0, 0, 1, 16'h0024, 3'b010, 32'h0, 32'h00000077, 1);

        // WAIT=0: single-cycle latency, back-to-back requests, combinational fetch
        access("W0 SW 4", 1, 1, 0, 16'h0004, 3'b010, 32'h00000055, 32'h0, 0);
        we[1] = 1'b1; addr[1] = 16'h0008; f3[1] = 3'b010; wd[1] = 32'h00000066;
        for (int i = 0; i < 6; i++) begin
            pc[1] = (i % 2 == 1) ? 16'h1000 : 16'h0004;
            #1 check($sformatf("W0 instr %0d", i), instr[1], (i % 2 == 1) ? 32'h13 : 32'h55);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("W0 b2b ready %0d", i), {31'b0, ready[1]}, (i % 2 == 0) ? 32'h1 : 32'h0);
        end
        we[1] = 1'b0;
        access("W0 LW 8", 1, 0, 1, 16'h0008, 3'b010, 32'h0, 32'h00000066, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
